// File: rtl/axis_complex_power_peak.sv
// Streaming |x|^2 of complex AXI-Stream bins with per-frame peak search.
// Two-stage square/sum pipeline; peak tracking runs on output handshakes.
`timescale 1ns/1ps

module axis_complex_power_peak #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int POWER_WIDTH      = 32,
    parameter int BIN_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    input  logic                        S_AXIS_tlast,
    output logic                        S_AXIS_tready,
    output logic [POWER_WIDTH-1:0]      M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    output logic                        M_AXIS_tlast,
    input  logic                        M_AXIS_tready,
    output logic [POWER_WIDTH-1:0]      peak_value,
    output logic [BIN_WIDTH-1:0]        peak_index,
    output logic                        peak_valid,
    output logic [31:0]                 frame_count
);

    localparam int HW = AXIS_TDATA_WIDTH / 2;
    localparam int PW = 2 * HW;

    logic signed [HW-1:0] re_s;
    logic signed [HW-1:0] im_s;

    logic                 rdy_q;
    logic                 en;
    logic                 accept;

    logic                 v1_q, v1_d;
    logic                 last1_q, last1_d;
    logic signed [PW-1:0] sq_re_q, sq_re_d;
    logic signed [PW-1:0] sq_im_q, sq_im_d;

    logic                   v2_q, v2_d;
    logic                   last2_q, last2_d;
    logic [POWER_WIDTH-1:0] pwr_q, pwr_d;

    logic                   hs;
    logic                   take;
    logic [POWER_WIDTH-1:0] cand_val;
    logic [BIN_WIDTH-1:0]   cand_idx;

    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [POWER_WIDTH-1:0] run_val_q, run_val_d;
    logic [BIN_WIDTH-1:0]   run_idx_q, run_idx_d;
    logic [POWER_WIDTH-1:0] pk_val_q, pk_val_d;
    logic [BIN_WIDTH-1:0]   pk_idx_q, pk_idx_d;
    logic                   pk_vld_q, pk_vld_d;
    logic [31:0]            fcnt_q, fcnt_d;

    assign re_s = S_AXIS_tdata[HW-1:0];
    assign im_s = S_AXIS_tdata[AXIS_TDATA_WIDTH-1:HW];

    // Both stages move as one; a held output freezes the whole pipe.
    assign en            = ~v2_q | M_AXIS_tready;
    assign S_AXIS_tready = rdy_q & en;
    assign accept        = S_AXIS_tvalid & S_AXIS_tready;

    always_comb begin
        v1_d    = v1_q;
        last1_d = last1_q;
        sq_re_d = sq_re_q;
        sq_im_d = sq_im_q;
        v2_d    = v2_q;
        last2_d = last2_q;
        pwr_d   = pwr_q;
        if (en) begin
            v1_d    = accept;
            last1_d = S_AXIS_tlast & accept;
            sq_re_d = re_s * re_s;
            sq_im_d = im_s * im_s;
            v2_d    = v1_q;
            last2_d = last1_q;
            pwr_d   = POWER_WIDTH'($unsigned(sq_re_q))
                    + POWER_WIDTH'($unsigned(sq_im_q));
        end
    end

    assign hs       = v2_q & M_AXIS_tready;
    // Strict compare keeps the earliest bin on ties.
    assign take     = (bin_q == '0) || (pwr_q > run_val_q);
    assign cand_val = take ? pwr_q : run_val_q;
    assign cand_idx = take ? bin_q : run_idx_q;

    always_comb begin
        bin_d     = bin_q;
        run_val_d = run_val_q;
        run_idx_d = run_idx_q;
        pk_val_d  = pk_val_q;
        pk_idx_d  = pk_idx_q;
        pk_vld_d  = 1'b0;
        fcnt_d    = fcnt_q;
        if (hs) begin
            run_val_d = cand_val;
            run_idx_d = cand_idx;
            if (last2_q) begin
                bin_d    = '0;
                pk_val_d = cand_val;
                pk_idx_d = cand_idx;
                pk_vld_d = 1'b1;
                fcnt_d   = fcnt_q + 32'd1;
            end else begin
                bin_d    = bin_q + BIN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdy_q   <= 1'b0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            pwr_q   <= '0;
        end else begin
            rdy_q   <= 1'b1;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            v2_q    <= v2_d;
            last2_q <= last2_d;
            pwr_q   <= pwr_d;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bin_q     <= '0;
            run_val_q <= '0;
            run_idx_q <= '0;
            pk_val_q  <= '0;
            pk_idx_q  <= '0;
            pk_vld_q  <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            bin_q     <= bin_d;
            run_val_q <= run_val_d;
            run_idx_q <= run_idx_d;
            pk_val_q  <= pk_val_d;
            pk_idx_q  <= pk_idx_d;
            pk_vld_q  <= pk_vld_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign M_AXIS_tdata  = pwr_q;
    assign M_AXIS_tvalid = v2_q;
    assign M_AXIS_tlast  = last2_q;
    assign peak_value    = pk_val_q;
    assign peak_index    = pk_idx_q;
    assign peak_valid    = pk_vld_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_axis_complex_power_peak.sv
// Scoreboard bench for axis_complex_power_peak.
// Driver pushes expected beats/peaks; negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_axis_complex_power_peak;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tlast;
    logic        S_AXIS_tready;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tlast;
    logic        M_AXIS_tready;
    logic [31:0] peak_value;
    logic [15:0] peak_index;
    logic        peak_valid;
    logic [31:0] frame_count;

    axis_complex_power_peak dut (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tready (M_AXIS_tready),
        .peak_value    (peak_value),
        .peak_index    (peak_index),
        .peak_valid    (peak_valid),
        .frame_count   (frame_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] p;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] v;
        logic [15:0] idx;
        logic [31:0] fc;
    } peak_t;

    beat_t exp_q[$];
    peak_t pk_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic send(input logic signed [15:0] re,
                        input logic signed [15:0] im,
                        input logic last, input logic [31:0] p);
        int  w;
        bit  ok;
        w  = 0;
        ok = 1'b0;
        S_AXIS_tdata  = {im, re};
        S_AXIS_tlast  = last;
        S_AXIS_tvalid = 1'b1;
        while (!ok) begin
            @(negedge aclk);
            if (S_AXIS_tready) ok = 1'b1;
            else begin
                w++;
                if (w > 500) begin
                    check("send_timeout", 0, 1);
                    break;
                end
            end
        end
        if (ok) exp_q.push_back(beat_t'{p, last});
        @(posedge aclk);
        #1;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || pk_q.size() != 0) && w < 3000) begin
            @(posedge aclk);
            w++;
        end
        check("drain_timeout", (w >= 3000), 0);
        repeat (4) @(posedge aclk);
        #1;
    endtask

    always @(posedge aclk) begin
        #1;
        M_AXIS_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [31:0] hold_d;
    logic        hold_l;
    bit          stalled = 1'b0;

    always @(negedge aclk) begin
        beat_t e;
        peak_t k;
        if (areset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", M_AXIS_tvalid, 1);
                check("stall_data", {M_AXIS_tlast, M_AXIS_tdata},
                      {hold_l, hold_d});
            end
            stalled = 1'b0;
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("tdata", M_AXIS_tdata, e.p);
                    check("tlast", M_AXIS_tlast, e.last);
                end
            end else if (M_AXIS_tvalid) begin
                stalled = 1'b1;
                hold_d  = M_AXIS_tdata;
                hold_l  = M_AXIS_tlast;
            end
            if (peak_valid) begin
                if (pk_q.size() == 0) check("unexpected_peak", 1, 0);
                else begin
                    k = pk_q.pop_front();
                    check("peak_value", peak_value, k.v);
                    check("peak_index", peak_index, k.idx);
                    check("frame_count", frame_count, k.fc);
                end
            end
        end
    end

    task automatic check_reset_state();
        check("rst_s_tready", S_AXIS_tready, 0);
        check("rst_m_tvalid", M_AXIS_tvalid, 0);
        check("rst_m_tlast", M_AXIS_tlast, 0);
        check("rst_m_tdata", M_AXIS_tdata, 0);
        check("rst_peak_value", peak_value, 0);
        check("rst_peak_index", peak_index, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_frame_count", frame_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r16, i16;
        int          rs, is;
        logic [31:0] p, mv;
        logic [15:0] mi;
        int          bin, fc;

        areset        = 1'b1;
        S_AXIS_tdata  = '0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        M_AXIS_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_state();
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("tready_before_edge", S_AXIS_tready, 0);
        @(posedge aclk);
        #1;
        check("tready_after_edge", S_AXIS_tready, 1);

        // single-beat frame, exact two-cycle latency
        pk_q.push_back(peak_t'{32'd25, 16'd0, 32'd1});
        send(16'sd3, 16'sd4, 1'b1, 32'd25);
        @(negedge aclk);
        check("lat_cycle1_idle", M_AXIS_tvalid, 0);
        @(negedge aclk);
        check("lat_cycle2_valid", M_AXIS_tvalid, 1);
        drain();

        // extremes, no overflow
        pk_q.push_back(peak_t'{32'h8000_0000, 16'd0, 32'd2});
        send(-16'sd32768, -16'sd32768, 1'b0, 32'h8000_0000);
        send(16'sh7FFF, 16'sh7FFF, 1'b1, 32'h7FFE_0002);
        drain();
        check("hold_peak_value", peak_value, 32'h8000_0000);
        check("hold_peak_index", peak_index, 0);
        check("hold_peak_valid", peak_valid, 0);

        // 8 bins, tie at 50 keeps index 2
        pk_q.push_back(peak_t'{32'd50, 16'd2, 32'd3});
        send(16'sd1, 16'sd0, 1'b0, 32'd1);
        send(16'sd0, -16'sd3, 1'b0, 32'd9);
        send(16'sd5, 16'sd5, 1'b0, 32'd50);
        send(-16'sd2, 16'sd0, 1'b0, 32'd4);
        send(16'sd7, -16'sd1, 1'b0, 32'd50);
        send(16'sd1, 16'sd1, 1'b0, 32'd2);
        send(16'sd0, 16'sd0, 1'b0, 32'd0);
        send(16'sd2, 16'sd1, 1'b1, 32'd5);
        drain();

        // 1024 beats, random data and random downstream stalls
        rand_rdy = 1'b1;
        fc = 3;
        mv = '0;
        mi = '0;
        for (int i = 0; i < 1024; i++) begin
            r16 = 16'($urandom);
            i16 = 16'($urandom);
            rs  = int'(signed'(r16));
            is  = int'(signed'(i16));
            p   = 32'(rs * rs) + 32'(is * is);
            bin = i % 64;
            if (bin == 0 || p > mv) begin
                mv = p;
                mi = 16'(bin);
            end
            if (bin == 63) begin
                fc++;
                pk_q.push_back(peak_t'{mv, mi, 32'(fc)});
            end
            send(r16, i16, (bin == 63), p);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // reset mid-frame with beats in flight
        for (int i = 0; i < 6; i++) send(16'sd1, 16'sd0, 1'b0, 32'd1);
        #1;
        areset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_state();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        check("tready_after_rst2", S_AXIS_tready, 1);
        pk_q.push_back(peak_t'{32'd16, 16'd1, 32'd1});
        send(16'sd2, 16'sd0, 1'b0, 32'd4);
        send(16'sd4, 16'sd0, 1'b0, 32'd16);
        send(16'sd3, 16'sd0, 1'b0, 32'd9);
        send(16'sd0, 16'sd4, 1'b1, 32'd16);
        drain();
        check("frame_count_final", frame_count, 1);

        check("exp_queue_empty", exp_q.size(), 0);
        check("peak_queue_empty", pk_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
